ram_port_arbiter: RTL

- Shares the single data RAM between two requesters: the CPU memory stage (port C) and an external agent such as an image loader or display reader (port X).
- Selects one access per cycle and drives the RAM address, data and write-enable from the granted port.
- Stalls the CPU pipeline when port C is denied, and routes the synchronous RAM read data back to the issuing port one cycle later.
- Sits between the ExecuteMemory register outputs and the RAM instance.

---
 rtl/ram_arb_pkg.sv | 22 ++
 rtl/ram_arb_fsm.sv | 103 ++++++++++
 rtl/ram_port_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the data-RAM port arbiter.
package ram_arb_pkg;

    localparam int unsigned ARB_ADDR_W    = 16;
    localparam int unsigned ARB_DATA_W    = 16;
    localparam int unsigned ARB_MAX_BURST = 4;
    // Wide enough for MAX_BURST up to 15
    localparam int unsigned BURST_W       = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_C    = 2'd1,
        OWN_X    = 2'd2
    } owner_e;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/ram_arb_fsm.sv
// Grant FSM: decides which port owns the RAM this cycle, bounding both
// X starvation under CPU traffic and X bursts while the CPU waits.
module ram_arb_fsm
    import ram_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = ARB_MAX_BURST
) (
    input  logic clk,
    input  logic rst,
    input  logic i_c_req,
    input  logic i_x_req,
    output logic o_c_gnt_c,
    output logic o_x_gnt_c
);

    owner_e             r_state;
    owner_e             r_last_owner;
    logic [BURST_W-1:0] r_burst_cnt;
    logic [1:0]         r_x_wait;

    logic w_c_gnt;
    logic w_x_gnt;
    logic w_x_starved;
    logic w_burst_ok;

    // X has been refused for two consecutive cycles
    assign w_x_starved = (r_x_wait == 2'd2);
    assign w_burst_ok  = (r_burst_cnt < BURST_W'(MAX_BURST));

    always_comb begin
        w_c_gnt = 1'b0;
        w_x_gnt = 1'b0;
        case (r_state)
            OWN_NONE: begin
                if (i_c_req && i_x_req) begin
                    w_c_gnt = (r_last_owner != OWN_C);
                    w_x_gnt = (r_last_owner == OWN_C);
                end else begin
                    w_c_gnt = i_c_req;
                    w_x_gnt = i_x_req;
                end
            end
            OWN_C: begin
                if (i_c_req && !(i_x_req && w_x_starved)) begin
                    w_c_gnt = 1'b1;
                end else if (i_x_req) begin
                    w_x_gnt = 1'b1;
                end
            end
            OWN_X: begin
                if (i_x_req && (!i_c_req || w_burst_ok)) begin
                    w_x_gnt = 1'b1;
                end else if (i_c_req) begin
                    w_c_gnt = 1'b1;
                end
            end
            default: begin
                w_c_gnt = i_c_req;
                w_x_gnt = i_x_req & ~i_c_req;
            end
        endcase
        // No access may reach the RAM while reset is held
        if (rst) begin
            w_c_gnt = 1'b0;
            w_x_gnt = 1'b0;
        end
    end

    assign o_c_gnt_c = w_c_gnt;
    assign o_x_gnt_c = w_x_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= OWN_NONE;
            r_last_owner <= OWN_X;
            r_burst_cnt  <= '0;
            r_x_wait     <= '0;
        end else begin
            if (w_c_gnt) begin
                r_state      <= OWN_C;
                r_last_owner <= OWN_C;
            end else if (w_x_gnt) begin
                r_state      <= OWN_X;
                r_last_owner <= OWN_X;
            end else begin
                r_state      <= OWN_NONE;
            end

            if (w_c_gnt || !w_x_gnt) begin
                r_burst_cnt <= '0;
            end else if (i_c_req && w_burst_ok) begin
                r_burst_cnt <= r_burst_cnt + BURST_W'(1);
            end

            if (i_x_req && !w_x_gnt) begin
                r_x_wait <= w_x_starved ? 2'd2 : r_x_wait + 2'd1;
            end else begin
                r_x_wait <= '0;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the data RAM between the CPU memory stage (C) and an external
// agent (X): grants one access per cycle and steers read data back.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ARB_ADDR_W,
    parameter int unsigned DATA_W    = ARB_DATA_W,
    parameter int unsigned MAX_BURST = ARB_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_stall,
    output logic              c_gnt,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_rvalid,
    input  logic              x_req,
    input  logic              x_we,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_wdata,
    output logic              x_gnt,
    output logic [DATA_W-1:0] x_rdata,
    output logic              x_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    logic              w_c_gnt;
    logic              w_x_gnt;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_data_hold;
    logic              r_rv_read;
    owner_e            r_rv_port;

    ram_arb_fsm #(
        .MAX_BURST (MAX_BURST)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .i_c_req   (c_req),
        .i_x_req   (x_req),
        .o_c_gnt_c (w_c_gnt),
        .o_x_gnt_c (w_x_gnt)
    );

    assign c_gnt   = w_c_gnt;
    assign x_gnt   = w_x_gnt;
    assign c_stall = c_req & ~w_c_gnt;

    // Idle cycles replay the last address/data so the RAM pins stay quiet
    always_comb begin
        ram_addr = r_addr_hold;
        ram_data = r_data_hold;
        ram_wren = 1'b0;
        if (w_c_gnt) begin
            ram_addr = c_addr;
            ram_data = c_wdata;
            ram_wren = c_we;
        end else if (w_x_gnt) begin
            ram_addr = x_addr;
            ram_data = x_wdata;
            ram_wren = x_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_hold <= '0;
            r_data_hold <= '0;
            r_rv_read   <= 1'b0;
            r_rv_port   <= OWN_NONE;
        end else begin
            r_addr_hold <= ram_addr;
            r_data_hold <= ram_data;
            r_rv_read   <= (w_c_gnt & ~c_we) | (w_x_gnt & ~x_we);
            r_rv_port   <= w_c_gnt ? OWN_C : (w_x_gnt ? OWN_X : OWN_NONE);
        end
    end

    // RAM output is shared; only the valids say who it belongs to
    assign c_rdata  = ram_q;
    assign x_rdata  = ram_q;
    assign c_rvalid = r_rv_read && (r_rv_port == OWN_C);
    assign x_rvalid = r_rv_read && (r_rv_port == OWN_X);

endmodule
